// File: rtl/dcm_ps_pkg.sv
// dcm_ps_pkg: shared state encoding, default parameters and shift-direction
// constants for the DCM phase-shift responder.
package dcm_ps_pkg;

  typedef enum logic [1:0] {
    LOCKING  = 2'd0,
    IDLE     = 2'd1,
    SHIFTING = 2'd2
  } ps_state_e;

  localparam int PS_LATENCY_DEF  = 12;
  localparam int PS_MAX_DEF      = 255;
  localparam int PHASE_W_DEF     = 9;
  localparam int LOCK_CYCLES_DEF = 64;
  localparam int SAMP_EDGE_DEF   = 20;

  localparam logic PS_DIR_INC = 1'b1;
  localparam logic PS_DIR_DEC = 1'b0;

endpackage

// File: rtl/dcm_ps_lockgen.sv
// dcm_ps_lockgen: counts consecutive cycles with dcm_rst low and raises locked
// after LOCK_CYCLES of them; dcm_rst clears the count and drops locked.
module dcm_ps_lockgen
  import dcm_ps_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic dcm_rst,
  output logic locked,
  output logic lock_fire
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    locked_d  = locked_q;
    lock_fire = 1'b0;
    if (dcm_rst) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (!locked_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(LOCK_CYCLES)) begin
        locked_d  = 1'b1;
        lock_fire = 1'b1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/dcm_ps_resp.sv
// dcm_ps_resp: DCM variable phase-shift responder (ps_en/ps_inc/ps_done, locked).
// Define DCM_PS_SAMPLE_EN to enable the registered samp_out phase-sample compare.
module dcm_ps_resp
  import dcm_ps_pkg::*;
#(
  parameter int PS_LATENCY  = PS_LATENCY_DEF,
  parameter int PS_MAX      = PS_MAX_DEF,
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
`ifdef DCM_PS_SAMPLE_EN
  ,
  parameter int SAMP_EDGE   = SAMP_EDGE_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dcm_rst,
  input  logic                      ps_en,
  input  logic                      ps_inc,
  output logic                      ps_done,
  output logic                      locked,
  output logic signed [PHASE_W-1:0] phase_ofs,
  output logic                      busy,
  output logic                      ps_sat,
  output logic                      proto_err,
  output logic                      samp_out
);

  localparam int                         LAT_W    = $clog2(PS_LATENCY);
  localparam logic [LAT_W-1:0]           LAT_LOAD = LAT_W'(PS_LATENCY - 1);
  localparam logic signed [PHASE_W-1:0]  PH_MAX   = PHASE_W'(PS_MAX);
  localparam logic signed [PHASE_W-1:0]  PH_MIN   = PHASE_W'(-PS_MAX);

  ps_state_e                 state_q, state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic                      dir_q, dir_d;
  logic                      done_q, done_d;
  logic                      sat_q, sat_d;
  logic                      err_q, err_d;
  logic signed [PHASE_W-1:0] phase_q, phase_d;
  logic                      lock_fire;

  dcm_ps_lockgen #(.LOCK_CYCLES(LOCK_CYCLES)) u_lockgen (
    .clk       (clk),
    .reset     (reset),
    .dcm_rst   (dcm_rst),
    .locked    (locked),
    .lock_fire (lock_fire)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    err_d   = err_q;
    phase_d = phase_q;

    if (ps_en && (state_q == SHIFTING || !locked)) err_d = 1'b1;

    // dcm_rst aborts any shift; the sticky flags survive until reset.
    if (dcm_rst) begin
      state_d = LOCKING;
      phase_d = '0;
    end else begin
      unique case (state_q)
        LOCKING: if (lock_fire) state_d = IDLE;
        IDLE: begin
          if (ps_en) begin
            dir_d   = ps_inc;
            lat_d   = LAT_LOAD;
            state_d = SHIFTING;
          end
        end
        SHIFTING: begin
          if (lat_q == LAT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dir_q == PS_DIR_INC) begin
              if (phase_q == PH_MAX) sat_d = 1'b1;
              else                   phase_d = phase_q + PHASE_W'(1);
            end else begin
              if (phase_q == PH_MIN) sat_d = 1'b1;
              else                   phase_d = phase_q - PHASE_W'(1);
            end
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        default: state_d = LOCKING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKING;
      lat_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      phase_q <= phase_d;
    end
  end

  assign ps_done   = done_q;
  assign busy      = (state_q == SHIFTING);
  assign ps_sat    = sat_q;
  assign proto_err = err_q;
  assign phase_ofs = phase_q;

`ifdef DCM_PS_SAMPLE_EN
  localparam logic signed [PHASE_W-1:0] SAMP_TH = PHASE_W'(SAMP_EDGE);

  logic samp_q, samp_d;

  // Sampled one cycle behind phase_ofs; cleared on the same edge locked drops.
  always_comb samp_d = locked && !dcm_rst && (phase_q >= SAMP_TH);

  always_ff @(posedge clk) begin
    if (reset) samp_q <= 1'b0;
    else       samp_q <= samp_d;
  end

  assign samp_out = samp_q;
`else
  assign samp_out = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_ps_resp.sv
// tb_dcm_ps_resp: directed and random stimulus for dcm_ps_resp, checked every
// cycle against a cycle-count/due-time model of the phase-shift handshake.
module tb_dcm_ps_resp;

  localparam int PS_LATENCY  = 12;
  localparam int PS_MAX      = 22;
  localparam int PHASE_W     = 9;
  localparam int LOCK_CYCLES = 64;
  localparam int SAMP_EDGE   = 20;
`ifdef DCM_PS_SAMPLE_EN
  localparam bit SAMPLE_ON = 1'b1;
`else
  localparam bit SAMPLE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, dcm_rst, ps_en, ps_inc;
  logic ps_done, locked, busy, ps_sat, proto_err, samp_out;
  logic signed [PHASE_W-1:0] phase_ofs;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, k, ndone;

  always #5 clk = ~clk;

  dcm_ps_resp #(
    .PS_LATENCY  (PS_LATENCY),
    .PS_MAX      (PS_MAX),
    .PHASE_W     (PHASE_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dcm_rst   (dcm_rst),
    .ps_en     (ps_en),
    .ps_inc    (ps_inc),
    .ps_done   (ps_done),
    .locked    (locked),
    .phase_ofs (phase_ofs),
    .busy      (busy),
    .ps_sat    (ps_sat),
    .proto_err (proto_err),
    .samp_out  (samp_out)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock = count of consecutive clean edges, a shift = a due
  // cycle number, phase = a plain integer clamped at +/-PS_MAX.
  int m_cyc = 0, m_cnt = 0, m_due = 0, m_phase = 0;
  bit m_locked = 0, m_inflight = 0, m_dir = 0, m_done = 0;
  bit m_sat = 0, m_err = 0, m_samp = 0, m_valid = 0;

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_cnt = 0; m_locked = 0; m_inflight = 0; m_phase = 0; m_done = 0;
      m_sat = 0; m_err = 0; m_samp = 0; m_valid = 1;
    end else begin
      m_samp = SAMPLE_ON && m_locked && !dcm_rst && (m_phase >= SAMP_EDGE);
      m_done = 0;
      if (ps_en && (m_inflight || !m_locked)) m_err = 1;
      if (dcm_rst) begin
        m_cnt = 0; m_locked = 0; m_inflight = 0; m_phase = 0;
      end else if (!m_locked) begin
        m_cnt++;
        if (m_cnt == LOCK_CYCLES) m_locked = 1;
      end else if (m_inflight) begin
        if (m_cyc == m_due) begin
          m_inflight = 0;
          m_done     = 1;
          if (m_dir) begin
            if (m_phase == PS_MAX) m_sat = 1; else m_phase++;
          end else begin
            if (m_phase == -PS_MAX) m_sat = 1; else m_phase--;
          end
        end
      end else if (ps_en) begin
        m_inflight = 1;
        m_dir      = ps_inc;
        m_due      = m_cyc + PS_LATENCY - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ps_done",   ps_done,   m_done);
      check("locked",    locked,    m_locked);
      check("phase_ofs", phase_ofs, m_phase);
      check("busy",      busy,      m_inflight);
      check("ps_sat",    ps_sat,    m_sat);
      check("proto_err", proto_err, m_err);
      check("samp_out",  samp_out,  m_samp);
    end
  end

  task automatic shift(input logic inc, output int l);
    ps_en = 1'b1; ps_inc = inc; l = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ps_en = 1'b0;
      l++;
      if (ps_done === 1'b1) break;
    end
    check("shift_done_seen", ps_done, 1'b1);
  endtask

  task automatic wait_lock(output int c);
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      c++;
      if (locked === 1'b1) break;
    end
    check("lock_seen", locked, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dcm_rst = 1'b0; ps_en = 1'b0; ps_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 1'b0);
    check("rst_phase",  phase_ofs, 0);
    check("rst_done",   ps_done, 1'b0);
    check("rst_busy",   busy, 1'b0);
    check("rst_sat",    ps_sat, 1'b0);
    check("rst_err",    proto_err, 1'b0);
    check("rst_samp",   samp_out, 1'b0);
    reset = 1'b0;

    // Request while still locking: ignored, flagged.
    repeat (3) @(negedge clk);
    ps_en = 1'b1; ps_inc = 1'b1;
    @(negedge clk);
    ps_en = 1'b0;
    check("unlocked_err",  proto_err, 1'b1);
    check("unlocked_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("unlocked_phase", phase_ofs, 0);

    reset = 1'b1;
    @(negedge clk);
    check("rst_clears_err", proto_err, 1'b0);
    reset = 1'b0;
    wait_lock(k);
    check("lock_time", k, 64);

    // Relock, with a dcm_rst pulse 30 cycles into the count.
    dcm_rst = 1'b1;
    @(negedge clk);
    check("dcm_rst_unlock", locked, 1'b0);
    dcm_rst = 1'b0;
    repeat (30) @(negedge clk);
    dcm_rst = 1'b1;
    @(negedge clk);
    dcm_rst = 1'b0;
    check("restart_unlocked", locked, 1'b0);
    wait_lock(k);
    check("relock_time", k, 64);

    // Single shifts, back-to-back from the ps_done cycle.
    shift(1'b1, lat);
    check("lat_inc", lat, 12);
    check("phase_inc", phase_ofs, 1);
    check("idle_at_done", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      shift(1'b0, lat);
      check("lat_dec", lat, 12);
    end
    check("phase_dec", phase_ofs, -2);
    check("no_err_yet", proto_err, 1'b0);
    @(negedge clk);
    check("done_one_cycle", ps_done, 1'b0);

    // Second request while busy.
    ps_en = 1'b1; ps_inc = 1'b1; ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      ps_en = (i == 5);
      if (ps_done === 1'b1) ndone++;
    end
    check("busy_one_done", ndone, 1);
    check("busy_err", proto_err, 1'b1);
    check("busy_phase", phase_ofs, -1);

    // Run up to the +PS_MAX clamp, then back down through SAMP_EDGE.
    for (int i = 0; i < 25; i++) begin
      shift(1'b1, lat);
      if (i == 20) begin
        check("phase_edge", phase_ofs, 20);
        check("samp_lag", samp_out, 1'b0);
        @(negedge clk);
        check("samp_rise", samp_out, SAMPLE_ON);
      end
      if (i == 22) check("sat_before", ps_sat, 1'b0);
    end
    check("phase_clamped", phase_ofs, 22);
    check("sat_set", ps_sat, 1'b1);
    shift(1'b0, lat);
    check("phase_after_sat", phase_ofs, 21);
    shift(1'b0, lat);
    shift(1'b0, lat);
    check("phase_below_edge", phase_ofs, 19);
    check("samp_still_high", samp_out, SAMPLE_ON);
    @(negedge clk);
    check("samp_fall", samp_out, 1'b0);

    // Abort an in-flight shift with dcm_rst at N+6.
    ps_en = 1'b1; ps_inc = 1'b1; ndone = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ps_en = 1'b0;
      if (ps_done === 1'b1) ndone++;
      if (i == 6) dcm_rst = 1'b1;
    end
    @(negedge clk);
    dcm_rst = 1'b0;
    check("abort_phase",  phase_ofs, 0);
    check("abort_locked", locked, 1'b0);
    check("abort_busy",   busy, 1'b0);
    check("abort_sat",    ps_sat, 1'b1);
    check("abort_err",    proto_err, 1'b1);
    wait_lock(k);
    check("abort_relock", k, 64);
    check("abort_no_done", ndone, 0);

    // Random traffic, with occasional dcm_rst and reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 1499) == 0);
      dcm_rst = ($urandom_range(0, 399) == 0);
      ps_en   = ($urandom_range(0, 7) == 0);
      ps_inc  = ($urandom_range(0, 2) != 0);
    end
    reset = 1'b0; dcm_rst = 1'b0; ps_en = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
